// File: rtl/fdiv_restoring_iter_gen.sv
// Iterative restoring significand divider: 3 quotient bits in the first cycle, then 4 per cycle.
// Define FDIV_RESTORING_ITER_GEN_F32_EN to add single-precision (fmt_i=1) support.
module fdiv_restoring_iter_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_valid_i,
    output logic        start_ready_o,
    input  logic        fmt_i,
    input  logic [52:0] fraca_i,
    input  logic [52:0] fracb_i,
    input  logic        flush_i,
    output logic        finish_valid_o,
    input  logic        finish_ready_i,
    output logic [54:0] quot_o,
    output logic [53:0] rem_o,
    output logic        rem_zero_o,
    output logic        fraca_lt_fracb_o,
    output logic        iter_start_o,
    output logic        iter_vld_o,
    output logic        iter_end_o,
    output logic [5:0]  iter_counter_o,
    output logic [5:0]  quot_bits_calculated_o,
    output logic [3:0]  quot_discard_num_one_hot_o
);
    typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

    state_t      r_state;
    logic [52:0] r_divisor;
    logic [53:0] r_rem;
    logic [54:0] r_qacc;
    logic [5:0]  r_counter;
    logic [5:0]  r_qbits;
    logic [54:0] r_quot;
    logic [53:0] r_rem_out;
    logic        r_rem_zero;
    logic        r_lt;
    logic [3:0]  r_discard;

    logic [52:0] w_fraca;
    logic [52:0] w_fracb;
    logic        w_lt;
    logic        w_accept;
    logic        w_last;
    logic        w_first;
    logic [5:0]  w_last_cnt;
    logic [3:0]  w_discard_sel;
    logic [54:0] w_s0, w_s1, w_s2, w_s3;
    logic [54:0] w_qacc_next;
    logic [53:0] w_rem_next;
    logic [53:0] w_rem_keep;
    logic [54:0] w_quot_res;
    logic [53:0] w_rem_res;

    // One restoring step; returns {quotient bit, next remainder}.
    function automatic logic [54:0] f_step(input logic [53:0] r, input logic shift,
                                           input logic [52:0] d);
        logic [53:0] x;
        logic [54:0] t;
        x = shift ? {r[52:0], 1'b0} : r;
        t = {1'b0, x} - {2'b00, d};
        return t[54] ? {1'b0, x} : {1'b1, t[53:0]};
    endfunction

`ifdef FDIV_RESTORING_ITER_GEN_F32_EN
    logic r_f32;

    // f32 runs on the f64 datapath scaled by 2^29; low bits are cleared so stray bits cannot leak in.
    assign w_fraca       = fmt_i ? {fraca_i[52:29], 29'd0} : fraca_i;
    assign w_fracb       = fmt_i ? {fracb_i[52:29], 29'd0} : fracb_i;
    assign w_discard_sel = fmt_i ? 4'b0100 : 4'b0010;
    assign w_last_cnt    = r_f32 ? 6'd6 : 6'd13;
    assign w_rem_keep    = r_f32 ? w_s1[53:0] : w_s2[53:0];
    assign w_quot_res    = r_f32 ? {2'b00, w_qacc_next[54:2]} : {1'b0, w_qacc_next[54:1]};
    assign w_rem_res     = r_f32 ? {29'd0, w_rem_keep[53:29]} : w_rem_keep;

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_f32 <= fmt_i;
        end
    end
`else
    logic w_unused_fmt;

    assign w_unused_fmt  = fmt_i;
    assign w_fraca       = fraca_i;
    assign w_fracb       = fracb_i;
    assign w_discard_sel = 4'b0010;
    assign w_last_cnt    = 6'd13;
    assign w_rem_keep    = w_s2[53:0];
    assign w_quot_res    = {1'b0, w_qacc_next[54:1]};
    assign w_rem_res     = w_rem_keep;
`endif

    assign w_lt     = w_fraca < w_fracb;
    assign w_accept = start_valid_i && (r_state == S_IDLE) && !rst;
    assign w_last   = (r_state == S_ITER) && (r_counter == w_last_cnt);
    assign w_first  = (r_counter == 6'd0);

    // The very first step of an operation compares R0 unshifted, since R0 < 2*D.
    assign w_s0 = f_step(r_rem, !w_first, r_divisor);
    assign w_s1 = f_step(w_s0[53:0], 1'b1, r_divisor);
    assign w_s2 = f_step(w_s1[53:0], 1'b1, r_divisor);
    assign w_s3 = f_step(w_s2[53:0], 1'b1, r_divisor);

    assign w_qacc_next = w_first ? {52'd0, w_s0[54], w_s1[54], w_s2[54]}
                                 : {r_qacc[50:0], w_s0[54], w_s1[54], w_s2[54], w_s3[54]};
    assign w_rem_next  = w_first ? w_s2[53:0] : w_s3[53:0];

    // NOTE: the datapath registers carry no reset; nothing reads them until an accept reloads them.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_divisor <= w_fracb;
            r_rem     <= w_lt ? {w_fraca, 1'b0} : {1'b0, w_fraca};
        end else if (r_state == S_ITER) begin
            r_rem  <= w_rem_next;
            r_qacc <= w_qacc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_counter  <= 6'd0;
            r_qbits    <= 6'd0;
            r_quot     <= 55'd0;
            r_rem_out  <= 54'd0;
            r_rem_zero <= 1'b1;
            r_lt       <= 1'b0;
            r_discard  <= 4'b0001;
        end else if (flush_i && r_state != S_IDLE) begin
            r_state   <= S_IDLE;
            r_counter <= 6'd0;
            r_qbits   <= 6'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_valid_i) begin
                        r_state   <= S_ITER;
                        r_counter <= 6'd0;
                        r_qbits   <= 6'd3;
                        r_lt      <= w_lt;
                        r_discard <= w_discard_sel;
                    end
                end
                S_ITER: begin
                    if (w_last) begin
                        r_state    <= S_DONE;
                        r_quot     <= w_quot_res;
                        r_rem_out  <= w_rem_res;
                        r_rem_zero <= (w_rem_keep == 54'd0);
                    end else begin
                        r_counter <= r_counter + 6'd1;
                        r_qbits   <= r_qbits + 6'd4;
                    end
                end
                S_DONE: begin
                    if (finish_ready_i) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign start_ready_o              = (r_state == S_IDLE);
    assign finish_valid_o             = (r_state == S_DONE);
    assign iter_start_o               = w_accept;
    assign iter_vld_o                 = (r_state == S_ITER);
    assign iter_end_o                 = w_last && !flush_i && !rst;
    assign iter_counter_o             = r_counter;
    assign quot_bits_calculated_o     = r_qbits;
    assign quot_o                     = r_quot;
    assign rem_o                      = r_rem_out;
    assign rem_zero_o                 = r_rem_zero;
    assign fraca_lt_fracb_o           = r_lt;
    assign quot_discard_num_one_hot_o = r_discard;

endmodule

// File: tb/tb_fdiv_restoring_iter_gen.sv
// Directed, table-driven bench for fdiv_restoring_iter_gen plus flush/reset/backpressure sequences.
// Expectations follow FDIV_RESTORING_ITER_GEN_F32_EN when it is defined.
module tb_fdiv_restoring_iter_gen;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_valid_i = 1'b0;
    logic        start_ready_o;
    logic        fmt_i = 1'b0;
    logic [52:0] fraca_i = '0;
    logic [52:0] fracb_i = '0;
    logic        flush_i = 1'b0;
    logic        finish_valid_o;
    logic        finish_ready_i = 1'b0;
    logic [54:0] quot_o;
    logic [53:0] rem_o;
    logic        rem_zero_o;
    logic        fraca_lt_fracb_o;
    logic        iter_start_o;
    logic        iter_vld_o;
    logic        iter_end_o;
    logic [5:0]  iter_counter_o;
    logic [5:0]  quot_bits_calculated_o;
    logic [3:0]  quot_discard_num_one_hot_o;

    always #5 clk = ~clk;

    fdiv_restoring_iter_gen dut (
        .clk                        (clk),
        .rst                        (rst),
        .start_valid_i              (start_valid_i),
        .start_ready_o              (start_ready_o),
        .fmt_i                      (fmt_i),
        .fraca_i                    (fraca_i),
        .fracb_i                    (fracb_i),
        .flush_i                    (flush_i),
        .finish_valid_o             (finish_valid_o),
        .finish_ready_i             (finish_ready_i),
        .quot_o                     (quot_o),
        .rem_o                      (rem_o),
        .rem_zero_o                 (rem_zero_o),
        .fraca_lt_fracb_o           (fraca_lt_fracb_o),
        .iter_start_o               (iter_start_o),
        .iter_vld_o                 (iter_vld_o),
        .iter_end_o                 (iter_end_o),
        .iter_counter_o             (iter_counter_o),
        .quot_bits_calculated_o     (quot_bits_calculated_o),
        .quot_discard_num_one_hot_o (quot_discard_num_one_hot_o)
    );

    typedef struct {
        logic        fmt;
        logic [52:0] a;
        logic [52:0] b;
        logic [54:0] quot;
        logic [53:0] rem;
        logic        rz;
        logic        lt;
        int          iters;
        logic [5:0]  qbits;
        logic [3:0]  onehot;
    } vec_t;

    int   n_checks = 0;
    int   n_pass   = 0;
    vec_t vecs[8];
    int   n_vec    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic fmt, input logic [52:0] a, input logic [52:0] b,
                                input logic [54:0] quot, input logic [53:0] rem,
                                input logic rz, input logic lt, input logic f32);
        vec_t v;
        v.fmt = fmt; v.a = a; v.b = b; v.quot = quot; v.rem = rem; v.rz = rz; v.lt = lt;
        v.iters  = f32 ? 7 : 14;
        v.qbits  = f32 ? 6'd27 : 6'd55;
        v.onehot = f32 ? 4'b0100 : 4'b0010;
        return v;
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, "_start_ready"}, start_ready_o, 1);
        check({tag, "_finish_valid"}, finish_valid_o, 0);
        check({tag, "_iter_flags"}, {iter_start_o, iter_vld_o, iter_end_o}, 0);
        check({tag, "_quot"}, quot_o, 0);
        check({tag, "_rem"}, rem_o, 0);
        check({tag, "_rem_zero"}, rem_zero_o, 1);
        check({tag, "_lt"}, fraca_lt_fracb_o, 0);
        check({tag, "_counter"}, iter_counter_o, 0);
        check({tag, "_qbits"}, quot_bits_calculated_o, 0);
        check({tag, "_onehot"}, quot_discard_num_one_hot_o, 4'b0001);
    endtask

    // Presents operands at a negedge; returns just after the accepting edge.
    task automatic start_op(input vec_t v);
        @(negedge clk);
        fmt_i = v.fmt; fraca_i = v.a; fracb_i = v.b; start_valid_i = 1'b1;
        @(posedge clk);
        #1 start_valid_i = 1'b0;
    endtask

    task automatic wait_counter(input logic [5:0] target);
        int guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!(iter_vld_o && iter_counter_o == target) && guard < 40);
        check("reach_counter", iter_vld_o && iter_counter_o == target, 1);
    endtask

    task automatic do_op(input string tag, input vec_t v, input int hold);
        int         cyc = 0, vld = 0, bad_seq = 0, end_cnt = 0;
        logic [5:0] end_qbits = '0;
        @(negedge clk);
        fmt_i = v.fmt; fraca_i = v.a; fracb_i = v.b; start_valid_i = 1'b1;
        #1;
        check({tag, "_start_ready"}, start_ready_o, 1);
        check({tag, "_iter_start"}, iter_start_o, 1);
        @(posedge clk);
        #1 start_valid_i = 1'b0;
        while (finish_valid_o !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (iter_start_o) bad_seq++;
            if (iter_vld_o) begin
                if (iter_counter_o != 6'(vld) || quot_bits_calculated_o != 6'(3 + 4 * vld)) bad_seq++;
                vld++;
                if (iter_end_o) begin
                    end_cnt++;
                    end_qbits = quot_bits_calculated_o;
                end
            end
        end
        check({tag, "_latency"}, cyc, v.iters + 1);
        check({tag, "_vld_cycles"}, vld, v.iters);
        check({tag, "_sequence"}, bad_seq, 0);
        check({tag, "_end_pulses"}, end_cnt, 1);
        check({tag, "_end_qbits"}, end_qbits, v.qbits);
        check({tag, "_quot"}, quot_o, v.quot);
        check({tag, "_rem"}, rem_o, v.rem);
        check({tag, "_rem_zero"}, rem_zero_o, v.rz);
        check({tag, "_lt"}, fraca_lt_fracb_o, v.lt);
        check({tag, "_onehot"}, quot_discard_num_one_hot_o, v.onehot);
        check({tag, "_done_qbits"}, quot_bits_calculated_o, v.qbits);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_state"}, {finish_valid_o, start_ready_o}, 2'b10);
            check({tag, "_hold_quot"}, quot_o, v.quot);
            check({tag, "_hold_rem"}, rem_o, v.rem);
        end
        finish_ready_i = 1'b1;
        @(posedge clk);
        #1 finish_ready_i = 1'b0;
        @(negedge clk);
        check({tag, "_back_idle"}, {start_ready_o, finish_valid_o}, 2'b10);
    endtask

    initial begin
        int bad;
        int guard;

        vecs[0] = mk(0, 53'h10000000000000, 53'h10000000000000, 55'h20000000000000, 54'h0, 1, 0, 0);
        vecs[1] = mk(0, 53'h18000000000000, 53'h10000000000000, 55'h30000000000000, 54'h0, 1, 0, 0);
        vecs[2] = mk(0, 53'h10000000000000, 53'h18000000000000, 55'h2AAAAAAAAAAAAA,
                     54'h10000000000000, 0, 1, 0);
        vecs[3] = mk(0, 53'h1FFFFFFFFFFFFF, 53'h10000000000000, 55'h3FFFFFFFFFFFFE, 54'h0, 1, 0, 0);
        vecs[4] = mk(0, 53'h10000000000000, 53'h1FFFFFFFFFFFFF, 55'h20000000000001, 54'h1, 0, 1, 0);
        n_vec = 5;
`ifdef FDIV_RESTORING_ITER_GEN_F32_EN
        vecs[5] = mk(1, {24'h800000, 29'd0}, {24'hC00000, 29'd0}, 55'h1555555, 54'h400000, 0, 1, 1);
        vecs[6] = mk(1, {24'hFFFFFF, 29'h1ABCDEF}, {24'h800000, 29'h0F0F0F0}, 55'h1FFFFFE, 54'h0, 1, 0, 1);
        n_vec = 7;
`else
        // Without f32 support fmt_i is ignored and the full 53-bit operands divide as f64.
        vecs[5] = mk(1, {24'h800000, 29'd0}, {24'hC00000, 29'd0}, 55'h2AAAAAAAAAAAAA,
                     54'h10000000000000, 0, 1, 0);
        n_vec = 6;
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        start_valid_i = 1'b1; fraca_i = vecs[0].a; fracb_i = vecs[0].b;
        #1 check("rst_blocks_start", iter_start_o, 0);
        @(posedge clk);
        #1 rst = 1'b0; start_valid_i = 1'b0;
        @(negedge clk);
        check_reset_state("reset");

        for (int i = 0; i < n_vec; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i], (i == 1) ? 3 : 0);
        end

        // Flush mid-iteration.
        start_op(vecs[0]);
        wait_counter(6'd5);
        flush_i = 1'b1;
        #1 check("flush_no_end", iter_end_o, 0);
        @(posedge clk);
        #1 flush_i = 1'b0;
        @(negedge clk);
        check("flush_idle", {start_ready_o, iter_vld_o, finish_valid_o}, 3'b100);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (finish_valid_o || iter_vld_o || iter_end_o) bad++;
        end
        check("flush_quiet", bad, 0);
        do_op("after_flush", vecs[2], 0);

        // Reset mid-iteration, then a clean operation.
        start_op(vecs[3]);
        wait_counter(6'd9);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_state("rst_iter");
        do_op("after_rst", vecs[4], 0);

        // Reset while holding a result in DONE.
        start_op(vecs[1]);
        guard = 0;
        while (finish_valid_o !== 1'b1 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check("reach_done", finish_valid_o, 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_state("rst_done");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fdiv_restoring_iter_gen.md
FDIV_RESTORING_ITER_GEN -- requirements
Module: fdiv_restoring_iter_gen

Interface
REQ-001 SHALL have exactly one clock and one reset; reset is synchronous and active-high.
REQ-002 SHALL expose the following ports, clock and reset first:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start_valid_i  in  1  operands valid
- start_ready_o  out  1  block can accept operands
- fmt_i  in  1  0=f64, 1=f32
- fraca_i  in  53  normalized dividend significand, bit52=1; f32 uses [52 -: 24]
- fracb_i  in  53  normalized divisor significand, bit52=1; f32 uses [52 -: 24]
- flush_i  in  1  abort current operation
- finish_valid_o  out  1  result valid
- finish_ready_i  in  1  result consumed
- quot_o  out  55  quotient; f64 in [53:0], f32 in [24:0], upper bits 0
- rem_o  out  54  final remainder; f32 in [24:0]
- rem_zero_o  out  1  rem_o==0
- fraca_lt_fracb_o  out  1  registered fraca<fracb
- iter_start_o  out  1  iteration-protocol start pulse
- iter_vld_o  out  1  iteration-protocol step valid
- iter_end_o  out  1  iteration-protocol last step
- iter_counter_o  out  6  iteration index
- quot_bits_calculated_o  out  6  quotient bits produced so far
- quot_discard_num_one_hot_o  out  4  discard count, one-hot: bit k = discard k

Function
REQ-003 SHALL implement FSM IDLE -> ITER -> DONE -> IDLE.
REQ-004 SHALL drive start_ready_o=1 only in IDLE.
REQ-005 On acceptance in IDLE (start_valid_i&start_ready_o), SHALL assert iter_start_o in that cycle; latch the divisor and fmt; latch R0 = fraca<fracb ? {a,0} : {0,a}; go to ITER.
REQ-006 In ITER, SHALL assert iter_vld_o every cycle.
REQ-007 SHALL start iter_counter_o at 0 in the first ITER cycle and increment it by 1 each ITER cycle.
REQ-008 Iteration 0 SHALL produce 3 quotient bits, with the first step comparing R unshifted; every later iteration SHALL produce 4 bits.
REQ-009 Restoring step SHALL be: T={R,0}-{0,D}; q=~borrow; R=q?T:{R,0}; invariant R<D.
REQ-010 SHALL use f64 = 14 iterations (55 bits computed, discard 1, one-hot 4'b0010) and f32 = 7 iterations (27 bits computed, discard 2, one-hot 4'b0100).
REQ-011 SHALL assert iter_end_o during the last ITER cycle (counter 13 or 6), with quot_bits_calculated_o = 55 or 27.
REQ-012 quot_bits_calculated_o SHALL equal 3+4*iter_counter_o during ITER and hold its final value in DONE.
REQ-013 At iter_end, SHALL register quot_o as the computed bits shifted right by the discard count, and rem_o as the remainder before the discarded steps.
REQ-014 Results SHALL satisfy quot_o*D + rem_o = R0<<(n-1), with n = 54 (f64) or 25 (f32).
REQ-015 Acceptance SHALL occur at cycle T; ITER occupies T+1..T+14 (f64) or T+1..T+7 (f32); finish_valid_o rises at T+15 or T+8.
REQ-016 In DONE, SHALL hold finish_valid_o=1 and keep all result outputs stable until finish_ready_i; the handshake cycle returns the FSM to IDLE.
REQ-017 flush_i SHALL have priority over every transition: it forces IDLE next cycle with no iter_end_o and no finish_valid_o; flush_i in IDLE has no effect.
REQ-018 iter_start_o/iter_vld_o/iter_end_o SHALL never be asserted outside the states above.

Reset
REQ-019 rst SHALL force IDLE on the next edge, from any state including mid-ITER and DONE.
REQ-020 After reset, SHALL drive start_ready_o=1; finish_valid_o, iter_*_o, quot_o, rem_o, iter_counter_o, quot_bits_calculated_o, fraca_lt_fracb_o = 0; rem_zero_o=1; quot_discard_num_one_hot_o=4'b0001.
REQ-021 rst SHALL take priority over flush_i and start_valid_i.

Configuration
REQ-022 With macro FDIV_RESTORING_ITER_GEN_F32_EN defined, SHALL support fmt_i=1 as in REQ-010.
REQ-023 Without FDIV_RESTORING_ITER_GEN_F32_EN, SHALL ignore fmt_i, treat every operation as f64, and omit the 25-bit datapath.

Verification
REQ-024 f64 a=b=0x10000000000000 -> 14 iter_vld_o cycles, quot_o=0x20000000000000, rem_o=0, rem_zero_o=1, finish_valid_o at T+15.
REQ-025 f64 a=0x18000000000000, b=0x10000000000000 -> fraca_lt_fracb_o=0, quot_o=0x30000000000000, rem_zero_o=1.
REQ-026 f32 a=[52-:24]=0x800000, b=[52-:24]=0xC00000 -> fraca_lt_fracb_o=1, 7 iterations, quot_o=0x1555555, rem_zero_o=0, quot_bits_calculated_o=27, discard one-hot 4'b0100.
REQ-027 f64 op with flush_i at iter_counter_o=5 -> next cycle start_ready_o=1, no iter_end_o, no finish_valid_o.
REQ-028 finish_ready_i=0 for 3 cycles in DONE -> quot_o/rem_o stable, start_ready_o=0; release -> IDLE next cycle.
REQ-029 rst asserted at iter_counter_o=9 -> all outputs equal REQ-020 values next cycle; a new operation then completes correctly.
